// File: rtl/demux7_capture_if.sv
// ----------------------------------------------------------------------------
// demux7_capture_if
//   Bundles the control, data and status signals of the 7-slot bit demux.
//   master : drives start/din/din_valid/wr_en/wr_sel, observes the status.
//   slave  : the capture block itself.
//   Signals:
//     start     request to begin a 7-bit sequential capture
//     din       serial data bit
//     din_valid din is meaningful this cycle (capture mode)
//     wr_en     addressed write strobe
//     wr_sel    slot index for an addressed write
//     q         registered slot contents
//     q_valid   a complete frame is held in q
//     ptr       current capture pointer
//     busy      capture in progress
//     done      one-cycle frame-complete pulse
// ----------------------------------------------------------------------------
interface demux7_capture_if #(
  parameter int N     = 7,
  parameter int PTR_W = 3
);
  logic             start;
  logic             din;
  logic             din_valid;
  logic             wr_en;
  logic [PTR_W-1:0] wr_sel;
  logic [N-1:0]     q;
  logic             q_valid;
  logic [PTR_W-1:0] ptr;
  logic             busy;
  logic             done;

  modport master (
    output start, din, din_valid, wr_en, wr_sel,
    input  q, q_valid, ptr, busy, done
  );

  modport slave (
    input  start, din, din_valid, wr_en, wr_sel,
    output q, q_valid, ptr, busy, done
  );
endinterface

// File: rtl/demux7_capture.sv
// ----------------------------------------------------------------------------
// demux7_capture
//   Steers a serial bit into one of N registered slots, either by an
//   addressed write (wr_sel) or by a sequential frame capture in which an
//   internal pointer walks slots 0..N-1, one bit per valid cycle.
//   Ports:
//     clock  system clock, rising edge
//     reset  asynchronous active-high reset
//     bus    demux7_capture_if.slave (see interface header)
// ----------------------------------------------------------------------------
module demux7_capture #(
  parameter int N     = 7,
  parameter int PTR_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  demux7_capture_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(N - 1);

  state_t           r_state, w_state_next;
  logic [N-1:0]     r_q, w_q_next;
  logic [PTR_W-1:0] r_ptr, w_ptr_next;
  logic             r_q_valid, w_q_valid_next;
  logic             w_wr_ok;

  // Codes N..2**PTR_W-1 do not name a slot; such writes are dropped.
  assign w_wr_ok = bus.wr_en && (32'(bus.wr_sel) < N);

  // NOTE: every signal gets its default first so no path leaves it
  // unassigned -- otherwise synthesis infers a latch.
  always_comb begin
    w_state_next   = r_state;
    w_q_next       = r_q;
    w_ptr_next     = r_ptr;
    w_q_valid_next = r_q_valid;

    unique case (r_state)
      S_IDLE, S_DONE: begin
        // DONE behaves like IDLE for one cycle so back-to-back starts work.
        if (r_state == S_DONE) w_state_next = S_IDLE;
        if (bus.start) begin
          w_state_next   = S_CAPTURE;
          w_q_next       = '0;
          w_ptr_next     = '0;
          w_q_valid_next = 1'b0;
        end else if (w_wr_ok) begin
          w_q_next[bus.wr_sel] = bus.din;
        end
      end

      S_CAPTURE: begin
        if (bus.din_valid) begin
          w_q_next[r_ptr] = bus.din;
          if (r_ptr == LAST_SLOT) begin
            w_ptr_next     = '0;
            w_q_valid_next = 1'b1;
            w_state_next   = S_DONE;
          end else begin
            w_ptr_next = r_ptr + 1'b1;
          end
        end
      end

      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_q       <= '0;
      r_ptr     <= '0;
      r_q_valid <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_q       <= w_q_next;
      r_ptr     <= w_ptr_next;
      r_q_valid <= w_q_valid_next;
    end
  end

  // All outputs come straight from registers or a decode of r_state.
  assign bus.q       = r_q;
  assign bus.q_valid = r_q_valid;
  assign bus.ptr     = r_ptr;
  assign bus.busy    = (r_state == S_CAPTURE);
  assign bus.done    = (r_state == S_DONE);

endmodule

// File: tb/tb_demux7_capture.sv
// ----------------------------------------------------------------------------
// tb_demux7_capture
//   Self-checking bench for demux7_capture: a table of directed vectors
//   followed by hand-written reset, gapped-capture and back-to-back sequences.
// ----------------------------------------------------------------------------
module tb_demux7_capture;

  logic clock;
  logic reset;

  demux7_capture_if bus ();

  demux7_capture dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       start;
    logic       wr_en;
    logic [2:0] wr_sel;
    logic       din;
    logic       dv;
    logic [6:0] q;
    logic       qv;
    logic [2:0] ptr;
    logic       busy;
    logic       done;
  } vec_t;

  int n_vec;
  int n_err;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [6:0] q,
                            input logic qv, input logic [2:0] ptr,
                            input logic busy, input logic done);
    check({tag, ".q"},       32'(bus.q),       32'(q));
    check({tag, ".q_valid"}, 32'(bus.q_valid), 32'(qv));
    check({tag, ".ptr"},     32'(bus.ptr),     32'(ptr));
    check({tag, ".busy"},    32'(bus.busy),    32'(busy));
    check({tag, ".done"},    32'(bus.done),    32'(done));
  endtask

  // Drive inputs on the falling edge, sample 1 ns after the rising edge.
  task automatic cycle(input logic s, input logic we, input logic [2:0] sel,
                       input logic d, input logic dv);
    @(negedge clock);
    bus.start     = s;
    bus.wr_en     = we;
    bus.wr_sel    = sel;
    bus.din       = d;
    bus.din_valid = dv;
    @(posedge clock);
    #1;
  endtask

  task automatic bit_in(input logic d);
    cycle(1'b0, 1'b0, 3'd0, d, 1'b1);
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  vec_t       vecs [15];
  logic [6:0] frame;
  logic [6:0] frame2;
  int         busy_cnt;

  initial begin
    n_vec = 0;
    n_err = 0;
    frame  = 7'b1001101;  // bit0 first: 1,0,1,1,0,0,1
    frame2 = 7'b0110010;

    //            st we sel  din dv  q           qv ptr   busy done
    vecs[0]  = '{0, 1, 3'd3, 1, 0, 7'b0001000, 0, 3'd0, 0, 0};
    vecs[1]  = '{0, 1, 3'd6, 1, 0, 7'b1001000, 0, 3'd0, 0, 0};
    vecs[2]  = '{0, 1, 3'd7, 1, 0, 7'b1001000, 0, 3'd0, 0, 0};
    vecs[3]  = '{0, 1, 3'd3, 0, 0, 7'b1000000, 0, 3'd0, 0, 0};
    vecs[4]  = '{1, 1, 3'd0, 1, 0, 7'b0000000, 0, 3'd0, 1, 0};
    vecs[5]  = '{0, 0, 3'd0, 1, 1, 7'b0000001, 0, 3'd1, 1, 0};
    vecs[6]  = '{1, 1, 3'd6, 1, 0, 7'b0000001, 0, 3'd1, 1, 0};
    vecs[7]  = '{0, 0, 3'd0, 0, 1, 7'b0000001, 0, 3'd2, 1, 0};
    vecs[8]  = '{0, 0, 3'd0, 1, 1, 7'b0000101, 0, 3'd3, 1, 0};
    vecs[9]  = '{0, 1, 3'd0, 1, 1, 7'b0001101, 0, 3'd4, 1, 0};
    vecs[10] = '{0, 0, 3'd0, 0, 1, 7'b0001101, 0, 3'd5, 1, 0};
    vecs[11] = '{0, 0, 3'd0, 0, 1, 7'b0001101, 0, 3'd6, 1, 0};
    vecs[12] = '{0, 0, 3'd0, 1, 1, 7'b1001101, 1, 3'd0, 0, 1};
    vecs[13] = '{0, 0, 3'd0, 0, 0, 7'b1001101, 1, 3'd0, 0, 0};
    vecs[14] = '{0, 1, 3'd1, 1, 0, 7'b1001111, 1, 3'd0, 0, 0};

    bus.start = 0; bus.wr_en = 0; bus.wr_sel = 0; bus.din = 0; bus.din_valid = 0;
    reset = 1'b1;
    #3;
    expect_out("reset", 7'd0, 0, 3'd0, 0, 0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      cycle(vecs[i].start, vecs[i].wr_en, vecs[i].wr_sel, vecs[i].din, vecs[i].dv);
      expect_out($sformatf("vec%0d", i), vecs[i].q, vecs[i].qv, vecs[i].ptr,
                 vecs[i].busy, vecs[i].done);
    end

    // Reset mid-capture: partial frame and q_valid vanish before any edge.
    cycle(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    for (int b = 0; b < 3; b++) bit_in(frame[b]);
    expect_out("pre_rst", 7'b0000101, 0, 3'd3, 1, 0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    expect_out("async_rst", 7'd0, 0, 3'd0, 0, 0);
    @(negedge clock);
    reset = 1'b0;

    cycle(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    for (int b = 0; b < 7; b++) bit_in(frame[b]);
    expect_out("post_rst_frame", frame, 1, 3'd0, 0, 1);
    idle_cycle();
    expect_out("done_one_cycle", frame, 1, 3'd0, 0, 0);

    // Gapped capture: two idle cycles ahead of every bit.
    busy_cnt = 0;
    cycle(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    if (bus.busy) busy_cnt++;
    for (int b = 0; b < 7; b++) begin
      for (int g = 0; g < 2; g++) begin
        idle_cycle();
        if (bus.busy) busy_cnt++;
      end
      check($sformatf("gap_ptr%0d", b), 32'(bus.ptr), b);
      bit_in(frame[b]);
      if (bus.busy) busy_cnt++;
    end
    expect_out("gapped_frame", frame, 1, 3'd0, 0, 1);
    check("gapped_busy_cycles", busy_cnt, 21);

    // Back-to-back: start accepted in the DONE cycle.
    cycle(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    expect_out("b2b_start", 7'd0, 0, 3'd0, 1, 0);
    for (int b = 0; b < 7; b++) bit_in(frame2[b]);
    expect_out("b2b_frame", frame2, 1, 3'd0, 0, 1);
    idle_cycle();
    expect_out("b2b_idle", frame2, 1, 3'd0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/demux7_capture.md
Name: demux7_capture

Overview:
- Inverse of the 7-to-1 bit selector: takes a single serial bit and steers it into one of 7 registered output slots.
- Two modes:
  - Addressed write: the slot is chosen by a select code.
  - Sequential frame capture: an internal pointer walks slots 0..6, taking one bit per valid cycle.
- Sits between a switch/serial source and the LEDR display path; reassembles a 7-bit word that the selector can later scan back out.

Parameters:
- N, 7, number of output slots (fixed at 7 for this lab; the 3-bit select codes below assume N=7).
- PTR_W, 3, width of the select and pointer codes.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a 7-bit sequential capture.
- din  input  1  serial data bit.
- din_valid  input  1  din is meaningful this cycle (capture mode only).
- wr_en  input  1  addressed write strobe.
- wr_sel  input  PTR_W  slot index for an addressed write.
- q  output  N  registered slot contents; drives LEDR[6:0].
- q_valid  output  1  a full 7-bit frame has been captured and is intact.
- ptr  output  PTR_W  current capture pointer.
- busy  output  1  high while in CAPTURE.
- done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (asynchronous, takes effect immediately, overrides everything): state=IDLE, q=0, ptr=0, q_valid=0, busy=0, done=0. Reset asserted mid-capture discards the partial frame.
- States: IDLE, CAPTURE, DONE. busy is decoded from state (high only in CAPTURE). done is high only in DONE.
- IDLE:
  - start=1: next state CAPTURE; q<=0, ptr<=0, q_valid<=0.
  - Else, wr_en=1 with wr_sel in 0..6: q[wr_sel]<=din. Other q bits, q_valid and ptr are unchanged.
  - wr_sel=7 is an invalid code: the write is dropped and q is unchanged. This mirrors the selector's default branch.
  - start and wr_en high together: start wins; the write is dropped.
- CAPTURE:
  - din_valid=1 and ptr<6: q[ptr]<=din, ptr<=ptr+1.
  - din_valid=1 and ptr==6: q[6]<=din, ptr<=0, q_valid<=1, next state DONE.
  - din_valid=0: hold all state; gaps of any length are allowed.
  - start and wr_en are ignored in CAPTURE.
- DONE: lasts exactly one cycle; done=1; then returns to IDLE. start=1 in DONE is accepted exactly as in IDLE (back-to-back frames). wr_en follows the IDLE rules.
- Latency:
  - A bit presented with din_valid at edge k appears on q after edge k.
  - done and q_valid rise on the same edge that writes q[6]; done is high for one cycle.
- q_valid stays high through IDLE until the next accepted start or reset. An addressed write does not clear it.
- ptr never exceeds 6. It wraps from 6 to 0 only on frame completion.
- All outputs are registered or decoded from registered state; no combinational path from any input to any output.

Test Plan:
- Reset during idle and mid-capture:
  - Assert reset after 3 valid bits -> q=0, ptr=0, busy=0, q_valid=0 immediately (asynchronously, before the next edge).
  - Then start and 7 valid bits 1,0,1,1,0,0,1 -> capture completes normally.
- Sequential capture: start, then 7 consecutive valid bits 1,0,1,1,0,0,1 (bit0 first) -> q=7'b1001101, done pulse of exactly 1 cycle on the 7th bit edge, q_valid=1, ptr=0, busy=0.
- Gapped capture: same data with din_valid low for 2 cycles between every bit -> identical q=7'b1001101. ptr holds during gaps, busy stays high for 21 cycles.
- Addressed writes:
  - From reset: wr_sel=3,din=1 then wr_sel=6,din=1 -> q=7'b1001000, q_valid stays 0.
  - wr_sel=7,din=1 -> q unchanged.
- Ignored and priority inputs:
  - wr_en=1, wr_sel=0, din=1 during CAPTURE -> no effect; start during CAPTURE -> no restart.
  - start+wr_en together in IDLE -> capture starts, q=0.
- Back-to-back frames: assert start in the DONE cycle -> second frame begins with no IDLE cycle; q_valid drops to 0 on that edge.
